// File: rtl/deser_pkg.sv
// Shared types and helpers for the word-to-frame deserializer.
// Holds the FSM encoding, packing-order constants and the length clamp.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_e;

    localparam bit MODE_MSB_FIRST = 1'b0;
    localparam bit MODE_LSB_FIRST = 1'b1;

    // A zero or oversized request means "a full frame".
    function automatic int eff_len(int len, int n);
        return (len == 0 || len > n) ? n : len;
    endfunction

endpackage

// File: rtl/deser_frame.sv
// Collects 1..N words of W bits into one packed frame with valid/ready on both sides.
// Supports MSB-first (shift) or LSB-first (slot) packing, abort and output backpressure.
module deser_frame
    import deser_pkg::*;
#(
    parameter int W         = 4,
    parameter int N         = 6,
    parameter int LSB_FIRST = 0,
    localparam int CNT_W    = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [W*N-1:0]   out_data,
    output logic [CNT_W-1:0] out_len,
    input  logic             out_ready,
    output logic             busy,
    output logic             done_tick
);

    localparam int FW = W * N;
    localparam bit LSB_MODE = (LSB_FIRST != 0) ? MODE_LSB_FIRST : MODE_MSB_FIRST;

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both high.
    state_e           state_q, state_d;
    logic [FW-1:0]    data_q, data_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = COLLECT;
                    len_d   = CNT_W'(eff_len(int'(len), N));
                    data_d  = '0;
                    cnt_d   = '0;
                end
            end
            COLLECT: begin
                if (abort) begin
                    state_d = IDLE;
                    data_d  = '0;
                    cnt_d   = '0;
                end else if (in_valid) begin
                    if (LSB_MODE == MODE_LSB_FIRST) begin
                        data_d[int'(cnt_q)*W +: W] = in_data;
                    end else begin
                        data_d = (data_q << W) | FW'(in_data);
                    end
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = HOLD;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    data_d  = '0;
                    cnt_d   = '0;
                end else if (out_ready) begin
                    if (start) begin
                        // Chain straight into the next frame without an IDLE bubble.
                        state_d = COLLECT;
                        len_d   = CNT_W'(eff_len(int'(len), N));
                        data_d  = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_data  = data_q;
    assign out_len   = len_q;
    assign done_tick = done_q;

endmodule

// File: tb/tb_deser_frame.sv
// Bench for deser_frame: one MSB-first and one LSB-first instance share all inputs.
// Table-driven frames plus hand sequences for abort, chaining and async reset.
module tb_deser_frame;

    localparam int W = 4;
    localparam int N = 6;
    localparam int CNT_W = 3;
    localparam int FW = W * N;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic             in_valid;
    logic [W-1:0]     in_data;
    logic             out_ready;

    logic             in_ready_m, out_valid_m, busy_m, done_m;
    logic [FW-1:0]    out_data_m;
    logic [CNT_W-1:0] out_len_m;
    logic             in_ready_l, out_valid_l, busy_l, done_l;
    logic [FW-1:0]    out_data_l;
    logic [CNT_W-1:0] out_len_l;

    deser_frame #(.W(W), .N(N), .LSB_FIRST(0)) u_msb (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_m),
        .out_valid(out_valid_m), .out_data(out_data_m), .out_len(out_len_m),
        .out_ready(out_ready), .busy(busy_m), .done_tick(done_m)
    );

    deser_frame #(.W(W), .N(N), .LSB_FIRST(1)) u_lsb (
        .clk(clk), .reset_n(reset_n), .start(start), .len(len), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_l),
        .out_valid(out_valid_l), .out_data(out_data_l), .out_len(out_len_l),
        .out_ready(out_ready), .busy(busy_l), .done_tick(done_l)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    logic [CNT_W+FW-1:0] exp_m_q[$];
    logic [CNT_W+FW-1:0] exp_l_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    logic                pv_m = 1'b0;
    logic                pv_l = 1'b0;
    logic [CNT_W+FW-1:0] e_m, e_l;

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid_m && out_ready) begin
                chk("pending_m", 32'(exp_m_q.size() > 0), 32'd1);
                if (exp_m_q.size() > 0) begin
                    e_m = exp_m_q.pop_front();
                    chk("frame_m", 32'({out_len_m, out_data_m}), 32'(e_m));
                end
            end
            if (out_valid_l && out_ready) begin
                chk("pending_l", 32'(exp_l_q.size() > 0), 32'd1);
                if (exp_l_q.size() > 0) begin
                    e_l = exp_l_q.pop_front();
                    chk("frame_l", 32'({out_len_l, out_data_l}), 32'(e_l));
                end
            end
            if (done_m || (out_valid_m && !pv_m))
                chk("done_tick_m", 32'(done_m), 32'(out_valid_m && !pv_m));
            if (done_l || (out_valid_l && !pv_l))
                chk("done_tick_l", 32'(done_l), 32'(out_valid_l && !pv_l));
        end
        pv_m = out_valid_m;
        pv_l = out_valid_l;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 ns after a rising edge.
    task automatic start_frame(logic [CNT_W-1:0] l);
        start = 1'b1;
        len   = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // seq holds the words in send order, first word in the top nibble.
    task automatic send_words(logic [FW-1:0] seq, int n, bit rnd);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 200) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = seq[(5-k)*W +: W];
            @(negedge clk);
            if (in_valid && in_ready_m) k++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("words_accepted", 32'(k), 32'(n));
    endtask

    task automatic finish_frame(int hold, logic [CNT_W-1:0] el, logic [FW-1:0] em, logic [FW-1:0] elsb);
        for (int i = 0; i <= hold; i++) begin
            chk("hold_valid_m", 32'(out_valid_m), 32'd1);
            chk("hold_valid_l", 32'(out_valid_l), 32'd1);
            chk("hold_in_ready", 32'({in_ready_m, in_ready_l}), 32'd0);
            chk("hold_len_m", 32'(out_len_m), 32'(el));
            chk("hold_len_l", 32'(out_len_l), 32'(el));
            chk("hold_data_m", 32'(out_data_m), 32'(em));
            chk("hold_data_l", 32'(out_data_l), 32'(elsb));
            if (i < hold) begin
                in_valid = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("released_valid", 32'({out_valid_m, out_valid_l}), 32'd0);
        chk("released_busy", 32'({busy_m, busy_l}), 32'd0);
    endtask

    task automatic push_exp(logic [CNT_W-1:0] el, logic [FW-1:0] em, logic [FW-1:0] elsb);
        exp_m_q.push_back({el, em});
        exp_l_q.push_back({el, elsb});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [CNT_W-1:0] len_in;
        logic [FW-1:0]    seq;
        int               n;
        bit               rnd;
        int               hold;
        logic [CNT_W-1:0] exp_len;
        logic [FW-1:0]    exp_m;
        logic [FW-1:0]    exp_l;
    } vec_t;

    vec_t tbl[6];

    task automatic run_vec(vec_t v);
        push_exp(v.exp_len, v.exp_m, v.exp_l);
        start_frame(v.len_in);
        send_words(v.seq, v.n, v.rnd);
        finish_frame(v.hold, v.exp_len, v.exp_m, v.exp_l);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        reset_n = 1'b0; start = 1'b0; len = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

        tbl[0] = '{3'd6, 24'h123456, 6, 1'b0, 3,  3'd6, 24'h123456, 24'h654321};
        tbl[1] = '{3'd3, 24'hABC000, 3, 1'b0, 1,  3'd3, 24'h000ABC, 24'h000CBA};
        tbl[2] = '{3'd0, 24'h789ABC, 6, 1'b0, 2,  3'd6, 24'h789ABC, 24'hCBA987};
        tbl[3] = '{3'd4, 24'h9E2D00, 4, 1'b1, 10, 3'd4, 24'h009E2D, 24'h00D2E9};
        tbl[4] = '{3'd1, 24'h500000, 1, 1'b0, 0,  3'd1, 24'h000005, 24'h000005};
        tbl[5] = '{3'd7, 24'hFEDCBA, 6, 1'b1, 0,  3'd6, 24'hFEDCBA, 24'hABCDEF};

        #3;
        chk("rst_flags_m", 32'({in_ready_m, out_valid_m, busy_m, done_m}), 32'd0);
        chk("rst_flags_l", 32'({in_ready_l, out_valid_l, busy_l, done_l}), 32'd0);
        chk("rst_data", 32'(out_data_m | out_data_l), 32'd0);
        chk("rst_len", 32'({out_len_m, out_len_l}), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) run_vec(tbl[i]);

        // abort after 2 of 5 words, with a word offered on the abort cycle
        start_frame(3'd5);
        send_words(24'h120000, 2, 1'b0);
        abort = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_flags", 32'({busy_m, busy_l, out_valid_m, out_valid_l, in_ready_m}), 32'd0);
        chk("abort_data", 32'(out_data_m | out_data_l), 32'd0);
        push_exp(3'd3, 24'h000789, 24'h000987);
        start_frame(3'd3);
        send_words(24'h789000, 3, 1'b0);
        finish_frame(1, 3'd3, 24'h000789, 24'h000987);

        // out_ready with start in HOLD chains straight into COLLECT
        push_exp(3'd2, 24'h000012, 24'h000021);
        start_frame(3'd2);
        send_words(24'h120000, 2, 1'b0);
        push_exp(3'd2, 24'h000034, 24'h000043);
        out_ready = 1'b1; start = 1'b1; len = 3'd2;
        @(posedge clk); #1;
        out_ready = 1'b0; start = 1'b0;
        chk("chain_collect", 32'({busy_m, in_ready_m, out_valid_m, busy_l, in_ready_l}), 32'b11011);
        send_words(24'h340000, 2, 1'b0);
        finish_frame(0, 3'd2, 24'h000034, 24'h000043);

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1; len = 3'd3;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", 32'({busy_m, in_ready_m, busy_l, in_ready_l}), 32'd0);

        // asynchronous reset mid-COLLECT
        start_frame(3'd4);
        send_words(24'h120000, 2, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_flags_m", 32'({in_ready_m, out_valid_m, busy_m, done_m}), 32'd0);
        chk("arst_flags_l", 32'({in_ready_l, out_valid_l, busy_l, done_l}), 32'd0);
        chk("arst_data", 32'(out_data_m | out_data_l), 32'd0);
        chk("arst_len", 32'({out_len_m, out_len_l}), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle", 32'({in_ready_m, busy_m, in_ready_l, busy_l}), 32'd0);
        run_vec(tbl[4]);

        @(posedge clk); #1;
        chk("queue_drained", 32'(exp_m_q.size() + exp_l_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
